msx_mouse_port: RTL and testbench



---
 rtl/msx_mouse_port_pkg.sv | 38 +++
 rtl/msx_mouse_port_if.sv | 32 +++
 rtl/msx_mouse_port_accum.sv | 73 +++++++
 rtl/msx_mouse_port.sv | 144 ++++++++++++++
 tb/tb_msx_mouse_port.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msx_mouse_port_pkg.sv
// ============================================================================
// Module  : msx_mouse_pkg
// Purpose : Shared types, constants and helpers for the MSX mouse port.
//           The optional accumulating mode is controlled by the macro
//           MSX_MOUSE_ACCUM_EN, which the accumulator sub-module reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package msx_mouse_pkg;

  // Width of the per-axis signed movement accumulator.
  localparam int MOUSE_ACC_W = 10;

  // Nibble sequencer phases, advanced once per strobe toggle.
  typedef enum logic [1:0] {
    X_HI = 2'd0,
    X_LO = 2'd1,
    Y_HI = 2'd2,
    Y_LO = 2'd3
  } phase_t;

  // Saturate a 10-bit signed value into the 8-bit range -128..127.
  function automatic logic [7:0] clamp8(input logic signed [MOUSE_ACC_W-1:0] v);
    logic [7:0] r;
    if (v > 10'sd127) begin
      r = 8'h7F;
    end else if (v < -10'sd128) begin
      r = 8'h80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msx_mouse_port_if.sv
// ============================================================================
// Module  : msx_mouse_port_if
// Purpose : Bundles the user_io mouse/joystick inputs, the emsx strobe and
//           the active-low port lines returned to emsx.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface msx_mouse_port_if;
  logic signed [8:0] mouse_x;
  logic signed [8:0] mouse_y;
  logic [7:0]        mouse_flags;
  logic              mouse_strobe;
  logic [5:0]        joy_n;
  logic              stra;
  logic [5:0]        port_n;
  logic              mouse_en;

  // Source side: user_io and emsx drive the inputs and observe the port.
  modport master (
    output mouse_x, mouse_y, mouse_flags, mouse_strobe, joy_n, stra,
    input  port_n, mouse_en
  );

  // Adapter side.
  modport slave (
    input  mouse_x, mouse_y, mouse_flags, mouse_strobe, joy_n, stra,
    output port_n, mouse_en
  );
endinterface

`default_nettype wire

// File: rtl/msx_mouse_port_accum.sv
// ============================================================================
// Module  : msx_mouse_accum
// Purpose : Per-axis movement store. Presents the saturated 8-bit snapshot of
//           its contents and updates on new deltas and on snapshot reads.
//           MSX_MOUSE_ACCUM_EN defined  : saturating add, residual carried.
//           MSX_MOUSE_ACCUM_EN undefined: latest delta only, cleared on read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module msx_mouse_accum
  import msx_mouse_pkg::*;
(
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          strobe_i,
  input  wire logic signed [MOUSE_ACC_W-1:0] delta_i,
  input  wire logic                          consume_i,
  output logic [7:0]                         snap_o
);

  logic signed [MOUSE_ACC_W-1:0] acc_q;
  logic signed [MOUSE_ACC_W-1:0] acc_d;

  assign snap_o = clamp8(acc_q);

`ifdef MSX_MOUSE_ACCUM_EN
  logic signed [MOUSE_ACC_W+1:0] w_sum;

  // Remove the value just read, add any new delta, saturate to 10 bits.
  // A read and a delta in the same cycle both apply, so nothing is lost.
  always_comb begin
    w_sum = {{2{acc_q[MOUSE_ACC_W-1]}}, acc_q};
    if (consume_i) begin
      w_sum = w_sum - {{4{snap_o[7]}}, snap_o};
    end
    if (strobe_i) begin
      w_sum = w_sum + {{2{delta_i[MOUSE_ACC_W-1]}}, delta_i};
    end
    if (w_sum > 12'sd511) begin
      acc_d = 10'sd511;
    end else if (w_sum < -12'sd512) begin
      acc_d = -10'sd512;
    end else begin
      acc_d = w_sum[MOUSE_ACC_W-1:0];
    end
  end
`else
  // Keep only the most recent delta; a read empties the store. A delta that
  // arrives with a read survives the clear.
  always_comb begin
    acc_d = acc_q;
    if (consume_i) begin
      acc_d = '0;
    end
    if (strobe_i) begin
      acc_d = delta_i;
    end
  end
`endif

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/msx_mouse_port.sv
// ============================================================================
// Module  : msx_mouse_port
// Purpose : MiST user_io to emsx joystick port A adapter. Auto-selects between
//           a digital joystick and an MSX-protocol mouse whose X/Y deltas are
//           sent as four nibbles clocked by strobe toggles.
//           Optional macro: MSX_MOUSE_ACCUM_EN (accumulate deltas between
//           reads instead of keeping only the latest one).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module msx_mouse_port
  import msx_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TMO_W          = 18
) (
  input  wire logic        clk_sys,
  input  wire logic        reset,
  msx_mouse_port_if.slave  bus
);

  localparam logic [TMO_W-1:0] c_tmo_reload = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] c_tmo_one    = TMO_W'(1);

  phase_t           phase_q, phase_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [5:0]       port_q, port_d;
  logic             mouse_en_q, mouse_en_d;
  logic             stra_q;
  logic [7:0]       sx_q, sx_d;
  logic [7:0]       sy_q, sy_d;

  logic [8:0]       w_dx9;
  logic [MOUSE_ACC_W-1:0] w_dx, w_dy;
  logic             w_toggle;
  logic             w_read;
  logic [7:0]       w_snap_x, w_snap_y;

  // MSX counts positive X to the left, so the user_io X delta is negated.
  assign w_dx9    = ~bus.mouse_x + 9'd1;
  assign w_dx     = {w_dx9[8], w_dx9};
  assign w_dy     = {bus.mouse_y[8], bus.mouse_y};
  assign w_toggle = bus.stra ^ stra_q;
  assign w_read   = mouse_en_q & w_toggle & (phase_q == X_HI);

  msx_mouse_accum u_acc_x (
    .clk       (clk_sys),
    .rst       (reset),
    .strobe_i  (bus.mouse_strobe),
    .delta_i   (w_dx),
    .consume_i (w_read),
    .snap_o    (w_snap_x)
  );

  msx_mouse_accum u_acc_y (
    .clk       (clk_sys),
    .rst       (reset),
    .strobe_i  (bus.mouse_strobe),
    .delta_i   (w_dy),
    .consume_i (w_read),
    .snap_o    (w_snap_y)
  );

  // Mode select, nibble sequencer, timeout and port data next-state.
  always_comb begin
    phase_d    = phase_q;
    tmo_d      = tmo_q;
    port_d     = port_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    mouse_en_d = mouse_en_q;

    if (bus.mouse_strobe) begin
      mouse_en_d = 1'b1;
    end else if (~&bus.joy_n) begin
      mouse_en_d = 1'b0;
    end

    if (!mouse_en_q) begin
      port_d  = bus.joy_n;
      phase_d = X_HI;
      tmo_d   = '0;
    end else begin
      port_d[5:4] = ~bus.mouse_flags[1:0];
      if (w_toggle) begin
        tmo_d = c_tmo_reload;
        case (phase_q)
          X_HI: begin
            sx_d        = w_snap_x;
            sy_d        = w_snap_y;
            port_d[3:0] = ~w_snap_x[7:4];
            phase_d     = X_LO;
          end
          X_LO: begin
            port_d[3:0] = ~sx_q[3:0];
            phase_d     = Y_HI;
          end
          Y_HI: begin
            port_d[3:0] = ~sy_q[7:4];
            phase_d     = Y_LO;
          end
          default: begin
            port_d[3:0] = ~sy_q[3:0];
            phase_d     = X_HI;
          end
        endcase
      end else if (tmo_q != '0) begin
        tmo_d = tmo_q - c_tmo_one;
        // The host stopped reading mid-sequence; restart from X high.
        if (tmo_q == c_tmo_one) begin
          phase_d = X_HI;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      phase_q    <= X_HI;
      tmo_q      <= '0;
      port_q     <= 6'h3F;
      mouse_en_q <= 1'b0;
      stra_q     <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
    end else begin
      phase_q    <= phase_d;
      tmo_q      <= tmo_d;
      port_q     <= port_d;
      mouse_en_q <= mouse_en_d;
      stra_q     <= bus.stra;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
    end
  end

  assign bus.port_n   = port_q;
  assign bus.mouse_en = mouse_en_q;

endmodule

`default_nettype wire

// File: tb/tb_msx_mouse_port.sv
// ============================================================================
// Module  : tb_msx_mouse_port
// Purpose : Self-checking bench for msx_mouse_port with a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msx_mouse_port;

  localparam int T  = 40;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  msx_mouse_port_if bus ();

  msx_mouse_port #(.TIMEOUT_CYCLES(T), .TMO_W(TW)) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  // Reference model state (plain integers).
  int m_en, m_phase, m_ax, m_ay, m_sx, m_sy, m_port;
  int m_stra_prev, m_edge, m_last, m_armed;

  function automatic int clamp8(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int sat10(int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  // Negate within 9-bit two's complement (negating -256 stays -256).
  function automatic int neg9(int x);
    int d;
    d = -x;
    if (d > 255) d = d - 512;
    return d;
  endfunction

  task automatic model_reset();
    m_en = 0; m_phase = 0; m_ax = 0; m_ay = 0; m_sx = 0; m_sy = 0;
    m_port = 63; m_stra_prev = 0; m_last = 0; m_armed = 0;
  endtask

  // Apply the currently driven inputs to the model, then advance one clock.
  task automatic cycle();
    int tog, cons, nib, dx, dy, strobe;
    strobe = int'(bus.mouse_strobe);
    dx     = neg9(int'(bus.mouse_x));
    dy     = int'(bus.mouse_y);
    tog    = (int'(bus.stra) != m_stra_prev) ? 1 : 0;
    cons   = 0;
    nib    = 0;
    if (m_en != 0) begin
      m_port = (m_port & 15) | ((3 - int'(bus.mouse_flags[1:0])) << 4);
      if (tog != 0) begin
        if (m_armed != 0 && (m_edge - m_last) > T) m_phase = 0;
        m_armed = 1;
        m_last  = m_edge;
        case (m_phase)
          0: begin
            m_sx = clamp8(m_ax);
            m_sy = clamp8(m_ay);
            cons = 1;
            nib  = (m_sx & 255) >> 4;
          end
          1: nib = m_sx & 15;
          2: nib = (m_sy & 255) >> 4;
          default: nib = m_sy & 15;
        endcase
        m_port  = (m_port & 48) | (15 - nib);
        m_phase = (m_phase + 1) % 4;
      end
    end else begin
      m_port  = int'(bus.joy_n);
      m_phase = 0;
      m_armed = 0;
    end
`ifdef MSX_MOUSE_ACCUM_EN
    if (cons != 0) begin m_ax = m_ax - m_sx; m_ay = m_ay - m_sy; end
    if (strobe != 0) begin m_ax = m_ax + dx; m_ay = m_ay + dy; end
    m_ax = sat10(m_ax);
    m_ay = sat10(m_ay);
`else
    if (cons != 0) begin m_ax = 0; m_ay = 0; end
    if (strobe != 0) begin m_ax = dx; m_ay = dy; end
`endif
    if (strobe != 0) m_en = 1;
    else if (bus.joy_n != 6'h3F) m_en = 0;
    m_stra_prev = int'(bus.stra);
    m_edge++;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_delta(int x, int y, int flags);
    bus.mouse_x      = 9'(x);
    bus.mouse_y      = 9'(y);
    bus.mouse_flags  = 8'(flags);
    bus.mouse_strobe = 1'b1;
    cycle();
    bus.mouse_strobe = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    cycle();
    checks++;
    if (bus.port_n !== 6'h3F || bus.mouse_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_values port_n=%h mouse_en=%b required 3f/0", bus.port_n, bus.mouse_en);
    end
    strobe_delta(-9, 7, 0);
    bus.stra = ~bus.stra; cycle();
    bus.stra = ~bus.stra; cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.port_n !== 6'h3F || bus.mouse_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset port_n=%h mouse_en=%b required 3f/0", bus.port_n, bus.mouse_en);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.stra  = 1'b0;
    bus.joy_n = 6'h3E;
    cycle();
    checks++;
    if (bus.port_n !== 6'h3E) begin
      errors++;
      $display("FAIL joy_after_reset port_n=%h required 3e", bus.port_n);
    end
    bus.joy_n = 6'h3F;
    cycle();
  endtask

  task automatic test_mouse_basic();
    logic [3:0] exp_nib [4];
    exp_nib[0] = 4'hF; exp_nib[1] = 4'hA; exp_nib[2] = 4'hF; exp_nib[3] = 4'hC;
    strobe_delta(-5, 3, 1);
    cycle();
    checks++;
    if (bus.mouse_en !== 1'b1 || bus.port_n[5:4] !== 2'b10) begin
      errors++;
      $display("FAIL mouse_enter mouse_en=%b buttons=%b required 1/10", bus.mouse_en, bus.port_n[5:4]);
    end
    for (int k = 0; k < 4; k++) begin
      bus.stra = ~bus.stra;
      cycle();
      checks++;
      if (bus.port_n[3:0] !== exp_nib[k] || bus.port_n !== 6'(m_port)) begin
        errors++;
        $display("FAIL basic_nibble%0d port_n=%h required %h", k, bus.port_n, 6'(m_port));
      end
      idle(3);
    end
  endtask

  task automatic test_saturation();
    strobe_delta(-255, -200, 0);
    strobe_delta(-255, -200, 0);
    strobe_delta(-255, -200, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        bus.stra = ~bus.stra;
        cycle();
        checks++;
        if (bus.port_n !== 6'(m_port)) begin
          errors++;
          $display("FAIL sat_read%0d_nib%0d port_n=%h required %h", r, k, bus.port_n, 6'(m_port));
        end
        if (r == 0 && k == 0) begin
          checks++;
          if (bus.port_n[3:0] !== 4'h8) begin
            errors++;
            $display("FAIL sat_first_xhi port_n=%h required nibble 8", bus.port_n);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] got;
    strobe_delta(-53, 114, 2);
    bus.stra = ~bus.stra; cycle();
    bus.stra = ~bus.stra; cycle();
    idle(5);
    strobe_delta(-33, 100, 2);
    idle(T);
    bus.stra = ~bus.stra; cycle();
    got = bus.port_n[3:0];
    checks++;
    if (got !== 4'hD) begin
      errors++;
      $display("FAIL timeout_restart nibble=%h required d", got);
    end
    bus.stra = ~bus.stra; cycle();
    checks++;
    if (bus.port_n[3:0] !== 4'hE) begin
      errors++;
      $display("FAIL timeout_xlo nibble=%h required e", bus.port_n[3:0]);
    end
    idle(T - 2);
    bus.stra = ~bus.stra; cycle();
    checks++;
    if (bus.port_n[3:0] !== 4'h9) begin
      errors++;
      $display("FAIL timeout_continue nibble=%h required 9", bus.port_n[3:0]);
    end
    bus.stra = ~bus.stra; cycle();
    checks++;
    if (bus.port_n[3:0] !== 4'hB) begin
      errors++;
      $display("FAIL timeout_ylo nibble=%h required b", bus.port_n[3:0]);
    end
  endtask

  task automatic test_coincident();
    strobe_delta(-10, 0, 0);
    bus.mouse_x      = -9'sd4;
    bus.mouse_y      = 9'sd0;
    bus.mouse_strobe = 1'b1;
    bus.stra         = ~bus.stra;
    cycle();
    bus.mouse_strobe = 1'b0;
    checks++;
    if (bus.port_n[3:0] !== 4'hF) begin
      errors++;
      $display("FAIL coinc_xhi nibble=%h required f", bus.port_n[3:0]);
    end
    bus.stra = ~bus.stra; cycle();
    checks++;
    if (bus.port_n[3:0] !== 4'h5) begin
      errors++;
      $display("FAIL coinc_xlo nibble=%h required 5", bus.port_n[3:0]);
    end
    bus.stra = ~bus.stra; cycle();
    bus.stra = ~bus.stra; cycle();
    bus.stra = ~bus.stra; cycle();
    bus.stra = ~bus.stra; cycle();
    checks++;
    if (bus.port_n[3:0] !== 4'hB) begin
      errors++;
      $display("FAIL coinc_residual nibble=%h required b", bus.port_n[3:0]);
    end
    bus.stra = ~bus.stra; cycle();
    bus.stra = ~bus.stra; cycle();
    bus.stra = ~bus.stra; cycle();
  endtask

  task automatic test_mode_switch();
    bus.joy_n = 6'h2F;
    cycle();
    checks++;
    if (bus.mouse_en !== 1'b0) begin
      errors++;
      $display("FAIL joy_exit mouse_en=%b required 0", bus.mouse_en);
    end
    cycle();
    checks++;
    if (bus.port_n !== 6'h2F) begin
      errors++;
      $display("FAIL joy_follow port_n=%h required 2f", bus.port_n);
    end
    strobe_delta(1, 1, 0);
    checks++;
    if (bus.mouse_en !== 1'b1) begin
      errors++;
      $display("FAIL strobe_priority mouse_en=%b required 1", bus.mouse_en);
    end
    bus.joy_n = 6'h3F;
    strobe_delta(1, 1, 0);
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.mouse_strobe = ($urandom_range(0, 9) == 0);
      bus.mouse_x      = 9'($urandom);
      bus.mouse_y      = 9'($urandom);
      bus.mouse_flags  = 8'($urandom);
      bus.joy_n        = ($urandom_range(0, 39) == 0) ? 6'($urandom) : 6'h3F;
      if ($urandom_range(0, 3) == 0) bus.stra = ~bus.stra;
      if ($urandom_range(0, 99) == 0) idle(T + $urandom_range(0, 3) - 2);
      cycle();
      checks++;
      if (bus.port_n !== 6'(m_port) || bus.mouse_en !== (m_en != 0)) begin
        errors++;
        $display("FAIL random%0d port_n=%h mouse_en=%b required %h/%0d", i, bus.port_n, bus.mouse_en, 6'(m_port), m_en);
      end
    end
    bus.mouse_strobe = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.mouse_x      = '0;
    bus.mouse_y      = '0;
    bus.mouse_flags  = '0;
    bus.mouse_strobe = 1'b0;
    bus.joy_n        = 6'h3F;
    bus.stra         = 1'b0;
    m_edge           = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_mouse_basic();
    test_saturation();
    test_timeout();
    test_coincident();
    test_mode_switch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
